// File: rtl/battle_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module   : battle_ctrl_gen2
// Purpose  : Second-generation battle controller. Sequences one battle turn
//            at a time (attack, heal, catch, switch). Covers speed-based turn
//            order, a party with voluntary and forced switching, finite potion
//            and ball inventories and a saturating turn counter. It drives the
//            HP/damage datapath strobes and the display/status outputs.
// Ports    :
//   clk, reset_n         clock, asynchronous active-low reset
//   go, move_op          menu handshake and selected move (00 battle, 01 heal,
//                        10 catch, 11 switch); accepted only in S_MENU
//   p_faster             player acts first (sampled in S_LOAD_PM)
//   ai_dead, p_dead      HP-zero indications from the datapath
//   catch_success        datapath catch roll (sampled in S_CATCH)
//   party_alive          per-slot alive mask
//   active_trainer, target, apply_ai_damage, apply_p_damage, p_heal,
//   catch, catch_fail, switch_en                datapath strobes
//   active_slot          current party slot
//   reject               one-cycle pulse when a menu go is refused
//   potions_left, balls_left, turn_count        inventory / turn status
//   victory, loss, caught                       terminal flags
//   state_id             encoded state for the HEX display
// Revision : 1.0 - initial release
// ============================================================================
module battle_ctrl_gen2 #(
  parameter int PARTY_SIZE = 6,
  parameter int POTIONS    = 3,
  parameter int BALLS      = 5,
  parameter int CNT_W      = 4,
  parameter int TURN_W     = 8,
  localparam int SLOT_W    = (PARTY_SIZE > 1) ? $clog2(PARTY_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic [1:0]            move_op,
  input  logic                  p_faster,
  input  logic                  ai_dead,
  input  logic                  p_dead,
  input  logic                  catch_success,
  input  logic [PARTY_SIZE-1:0] party_alive,
  output logic                  active_trainer,
  output logic                  target,
  output logic                  apply_ai_damage,
  output logic                  apply_p_damage,
  output logic                  p_heal,
  output logic                  catch,
  output logic                  catch_fail,
  output logic                  switch_en,
  output logic [SLOT_W-1:0]     active_slot,
  output logic                  reject,
  output logic [CNT_W-1:0]      potions_left,
  output logic [CNT_W-1:0]      balls_left,
  output logic [TURN_W-1:0]     turn_count,
  output logic                  victory,
  output logic                  loss,
  output logic                  caught,
  output logic [3:0]            state_id
);

  typedef enum logic [3:0] {
    S_MENU       = 4'd0,
    S_LOAD_PM    = 4'd1,
    S_P_ATTACK   = 4'd2,
    S_AI_ATTACK  = 4'd3,
    S_P_HEAL     = 4'd4,
    S_CATCH      = 4'd5,
    S_FAIL_CATCH = 4'd6,
    S_SWITCH     = 4'd7,
    S_FAINT      = 4'd8,
    S_TURN_END   = 4'd9,
    S_VICTORY    = 4'd10,
    S_LOSS       = 4'd11,
    S_CAUGHT     = 4'd12
  } state_t;

  localparam logic [CNT_W-1:0]      c_potions_init = CNT_W'(POTIONS);
  localparam logic [CNT_W-1:0]      c_balls_init   = CNT_W'(BALLS);
  localparam logic [TURN_W-1:0]     c_turn_max     = '1;
  localparam logic [SLOT_W:0]       c_party        = (SLOT_W+1)'(PARTY_SIZE);
  localparam logic [PARTY_SIZE-1:0] c_slot0        = PARTY_SIZE'(1);

  state_t              r_state;
  state_t              w_next;
  logic                r_first;     // player moves first in the current turn
  logic                r_forced;    // current switch was caused by a faint
  logic [SLOT_W-1:0]   r_active_slot;
  logic [CNT_W-1:0]    r_potions;
  logic [CNT_W-1:0]    r_balls;
  logic [TURN_W-1:0]   r_turns;
  logic                w_reject;
  logic                w_override_en;
  logic [PARTY_SIZE-1:0] w_others;
  logic                w_other_alive;
  logic [SLOT_W-1:0]   w_switch_slot;
  logic [SLOT_W:0]     w_idx;
  logic                w_found;

  // Alive slots other than the active one.
  assign w_others      = party_alive & ~(c_slot0 << r_active_slot);
  assign w_other_alive = |w_others;

  // Search forward from the active slot with wrap-around; the first alive
  // slot found is the switch target. The active slot itself is never chosen.
  always_comb begin
    w_switch_slot = r_active_slot;
    w_found       = 1'b0;
    w_idx         = '0;
    for (int k = 1; k < PARTY_SIZE; k++) begin
      w_idx = {1'b0, r_active_slot} + (SLOT_W+1)'(k);
      if (w_idx >= c_party) begin
        w_idx = w_idx - c_party;
      end
      if (!w_found && party_alive[w_idx[SLOT_W-1:0]]) begin
        w_switch_slot = w_idx[SLOT_W-1:0];
        w_found       = 1'b1;
      end
    end
  end

  // KO checks are skipped in terminal states, in FAINT (which handles p_dead
  // itself) and in SWITCH (the datapath is still loading the new HP).
  always_comb begin
    w_override_en = 1'b1;
    case (r_state)
      S_VICTORY, S_LOSS, S_CAUGHT, S_FAINT, S_SWITCH: w_override_en = 1'b0;
      default:                                        w_override_en = 1'b1;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_reject = 1'b0;
    case (r_state)
      S_MENU: begin
        if (go) begin
          case (move_op)
            2'b00: w_next = S_LOAD_PM;
            2'b01: begin
              if (r_potions != '0) w_next   = S_P_HEAL;
              else                 w_reject = 1'b1;
            end
            2'b10: begin
              if (r_balls != '0) w_next   = S_CATCH;
              else               w_reject = 1'b1;
            end
            default: begin
              if (w_other_alive) w_next   = S_SWITCH;
              else               w_reject = 1'b1;
            end
          endcase
        end
      end
      S_LOAD_PM:    w_next = p_faster ? S_P_ATTACK : S_AI_ATTACK;
      S_P_ATTACK:   w_next = r_first ? S_AI_ATTACK : S_TURN_END;
      S_AI_ATTACK:  w_next = r_first ? S_TURN_END : S_P_ATTACK;
      S_P_HEAL:     w_next = S_AI_ATTACK;
      S_CATCH:      w_next = catch_success ? S_CAUGHT : S_FAIL_CATCH;
      S_FAIL_CATCH: w_next = S_AI_ATTACK;
      S_SWITCH:     w_next = r_forced ? S_MENU : S_AI_ATTACK;
      S_FAINT:      w_next = w_other_alive ? S_SWITCH : S_LOSS;
      S_TURN_END:   w_next = S_MENU;
      S_VICTORY, S_LOSS, S_CAUGHT: w_next = r_state;
      default:      w_next = S_MENU;
    endcase

    // A KO takes priority over whatever the turn would do next; an AI KO
    // wins over a simultaneous player KO.
    if (w_override_en) begin
      if (ai_dead) begin
        w_next   = S_VICTORY;
        w_reject = 1'b0;
      end else if (p_dead) begin
        w_next   = S_FAINT;
        w_reject = 1'b0;
      end
    end
  end

  // Single state register; all outputs are registered from the next state so
  // they are aligned with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_MENU;
      r_first         <= 1'b0;
      r_forced        <= 1'b0;
      r_active_slot   <= '0;
      r_potions       <= c_potions_init;
      r_balls         <= c_balls_init;
      r_turns         <= '0;
      active_trainer  <= 1'b0;
      target          <= 1'b0;
      apply_ai_damage <= 1'b0;
      apply_p_damage  <= 1'b0;
      p_heal          <= 1'b0;
      catch           <= 1'b0;
      catch_fail      <= 1'b0;
      switch_en       <= 1'b0;
      reject          <= 1'b0;
      victory         <= 1'b0;
      loss            <= 1'b0;
      caught          <= 1'b0;
    end else begin
      r_state <= w_next;

      // Heal, failed catch and voluntary switch all give the AI its move
      // after the player's action, which is the "player first" ordering.
      if (r_state == S_LOAD_PM) begin
        r_first <= p_faster;
      end else if (r_state == S_P_HEAL || r_state == S_FAIL_CATCH ||
                   r_state == S_SWITCH) begin
        r_first <= 1'b1;
      end

      // The slot moves on entry so switch_en and the new slot coincide.
      if (w_next == S_SWITCH && r_state != S_SWITCH) begin
        r_active_slot <= w_switch_slot;
        r_forced      <= (r_state == S_FAINT);
      end

      if (r_state == S_P_HEAL && r_potions != '0) begin
        r_potions <= r_potions - 1'b1;
      end
      if (r_state == S_CATCH && r_balls != '0) begin
        r_balls <= r_balls - 1'b1;
      end
      if (r_state == S_TURN_END && r_turns != c_turn_max) begin
        r_turns <= r_turns + 1'b1;
      end

      active_trainer  <= (w_next == S_AI_ATTACK);
      target          <= (w_next == S_P_ATTACK);
      apply_ai_damage <= (w_next == S_P_ATTACK);
      apply_p_damage  <= (w_next == S_AI_ATTACK);
      p_heal          <= (w_next == S_P_HEAL);
      catch           <= (w_next == S_CATCH);
      catch_fail      <= (w_next == S_FAIL_CATCH);
      switch_en       <= (w_next == S_SWITCH);
      reject          <= w_reject;
      victory         <= (w_next == S_VICTORY);
      loss            <= (w_next == S_LOSS);
      caught          <= (w_next == S_CAUGHT);
    end
  end

  assign active_slot  = r_active_slot;
  assign potions_left = r_potions;
  assign balls_left   = r_balls;
  assign turn_count   = r_turns;
  assign state_id     = r_state;

endmodule
`default_nettype wire
